// File: rtl/alu_exec_stage.sv
// Execute stage: accepts one op per valid/ready handshake, dispatches to the
// 8-bit ALU, and holds the result in a backpressured output slot. MUL takes
// MUL_LATENCY cycles; every other op (including illegal encodings) takes one.
module alu_exec_stage #(
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_err,
  output logic [15:0]      op_count
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpMul = 3'b010;
  localparam logic [2:0] OpAnd = 3'b011;
  localparam logic [2:0] OpOr  = 3'b100;
  localparam logic [2:0] OpXor = 3'b101;

  // Counter preload; a latency of 1 never enters the wait state.
  localparam logic [3:0] MulCntInit = 4'(MUL_LATENCY - 1);
  localparam bit         MulMulti   = (MUL_LATENCY > 1);

  typedef enum logic [0:0] {StIdle, StMulWait} state_e;

  state_e             r_state, w_state_next;
  logic [3:0]         r_cnt, w_cnt_next;
  logic [7:0]         r_mul_a, r_mul_b;
  logic [TAG_W-1:0]   r_mul_tag;

  logic               r_out_valid;
  logic [7:0]         r_out_result;
  logic [TAG_W-1:0]   r_out_tag;
  logic               r_out_zero;
  logic               r_out_err;
  logic [15:0]        r_op_count;

  logic               w_slot_free;
  logic               w_accept;
  logic               w_out_hs;
  logic               w_mul_start;
  logic               w_load;
  logic [7:0]         w_load_result;
  logic [TAG_W-1:0]   w_load_tag;
  logic               w_load_err;
  logic               w_load_zero;
  logic [7:0]         w_alu_result;
  logic               w_alu_err;
  logic [15:0]        w_in_prod;
  logic [15:0]        w_mul_prod;

  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = !rst && (r_state == StIdle) && w_slot_free;
  assign w_accept    = in_valid && in_ready;
  assign w_out_hs    = r_out_valid && out_ready;
  assign w_in_prod   = in_a * in_b;
  assign w_mul_prod  = r_mul_a * r_mul_b;
  assign w_load_zero = !w_load_err && (w_load_result == 8'h00);

  // Single-cycle ALU on the incoming operands; high product/carry bits drop.
  always_comb begin
    w_alu_result = 8'h00;
    w_alu_err    = 1'b0;
    case (in_op)
      OpAdd:   w_alu_result = in_a + in_b;
      OpSub:   w_alu_result = in_a - in_b;
      OpMul:   w_alu_result = w_in_prod[7:0];
      OpAnd:   w_alu_result = in_a & in_b;
      OpOr:    w_alu_result = in_a | in_b;
      OpXor:   w_alu_result = in_a ^ in_b;
      default: w_alu_err    = 1'b1;
    endcase
  end

  // FSM next state, MUL countdown and output-slot load selection.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_mul_start   = 1'b0;
    w_load        = 1'b0;
    w_load_result = 8'h00;
    w_load_tag    = '0;
    w_load_err    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if ((in_op == OpMul) && MulMulti) begin
            w_mul_start  = 1'b1;
            w_cnt_next   = MulCntInit;
            w_state_next = StMulWait;
          end else begin
            w_load        = 1'b1;
            w_load_result = w_alu_result;
            w_load_tag    = in_tag;
            w_load_err    = w_alu_err;
          end
        end
      end
      StMulWait: begin
        if (r_cnt != 4'd0) begin
          w_cnt_next = r_cnt - 4'd1;
        end else if (w_slot_free) begin
          w_load        = 1'b1;
          w_load_result = w_mul_prod[7:0];
          w_load_tag    = r_mul_tag;
          w_state_next  = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM state, MUL operand latch and countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= 4'd0;
      r_mul_a   <= 8'h00;
      r_mul_b   <= 8'h00;
      r_mul_tag <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_mul_start) begin
        r_mul_a   <= in_a;
        r_mul_b   <= in_b;
        r_mul_tag <= in_tag;
      end
    end
  end

  // Output slot: a new load wins over a handshake clear; fields hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= 8'h00;
      r_out_tag    <= '0;
      r_out_zero   <= 1'b0;
      r_out_err    <= 1'b0;
    end else if (w_load) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_load_result;
      r_out_tag    <= w_load_tag;
      r_out_zero   <= w_load_zero;
      r_out_err    <= w_load_err;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  // Saturating count of output handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count <= 16'h0000;
    end else if (w_out_hs && (r_op_count != 16'hFFFF)) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;
  assign out_zero   = r_out_zero;
  assign out_err    = r_out_err;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: a transaction-level reference model compared every
// cycle, plus hand-computed literal checks on directed vectors.
module tb_alu_exec_stage;

  localparam int MUL_LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_zero, out_err;
  logic [2:0] in_op;
  logic [7:0] in_a, in_b, out_result;
  logic [3:0] in_tag, out_tag;
  logic [15:0] op_count;

  logic       s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready, s1_out_zero, s1_out_err;
  logic [2:0] s1_in_op;
  logic [7:0] s1_in_a, s1_in_b, s1_out_result;
  logic [3:0] s1_in_tag, s1_out_tag;
  logic [15:0] s1_op_count;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_exec_stage #(.MUL_LATENCY(MUL_LAT), .TAG_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
    .out_zero(out_zero), .out_err(out_err), .op_count(op_count)
  );

  alu_exec_stage #(.MUL_LATENCY(1), .TAG_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .in_op(s1_in_op), .in_a(s1_in_a), .in_b(s1_in_b), .in_tag(s1_in_tag),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_result(s1_out_result),
    .out_tag(s1_out_tag), .out_zero(s1_out_zero), .out_err(s1_out_err),
    .op_count(s1_op_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU: returns {err, result} from plain integer arithmetic.
  function automatic logic [8:0] ref_alu(input int op, input int a, input int b);
    case (op)
      0: return {1'b0, 8'((a + b) % 256)};
      1: return {1'b0, 8'((a - b + 256) % 256)};
      2: return {1'b0, 8'((a * b) % 256)};
      3: return {1'b0, 8'(a & b)};
      4: return {1'b0, 8'(a | b)};
      5: return {1'b0, 8'(a ^ b)};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  // Model state: slot contents, handshake count, and a pending MUL with its due cycle.
  bit         m_valid, m_zero, m_err, m_busy;
  logic [7:0] m_res;
  logic [3:0] m_tag, m_ptag;
  int         m_cnt, m_pa, m_pb;
  longint     m_cyc = 0, m_done = 0;

  always @(posedge clk) begin
    bit ready, hs, acc;
    logic [8:0] r;
    if (rst) begin
      m_valid = 0; m_res = 0; m_tag = 0; m_zero = 0; m_err = 0; m_cnt = 0; m_busy = 0;
    end else begin
      ready = !m_busy && (!m_valid || out_ready);
      hs    = m_valid && out_ready;
      acc   = in_valid && ready;
      if (hs) begin
        m_valid = 0;
        if (m_cnt < 65535) m_cnt++;
      end
      if (m_busy && m_cyc >= m_done && !m_valid) begin
        r = ref_alu(2, m_pa, m_pb);
        m_valid = 1; m_res = r[7:0]; m_err = 0; m_zero = (r[7:0] == 0); m_tag = m_ptag;
        m_busy = 0;
      end
      if (acc) begin
        if (in_op == 3'd2 && MUL_LAT > 1) begin
          m_busy = 1; m_done = m_cyc + MUL_LAT;
          m_pa = int'(in_a); m_pb = int'(in_b); m_ptag = in_tag;
        end else begin
          r = ref_alu(int'(in_op), int'(in_a), int'(in_b));
          m_valid = 1; m_res = r[7:0]; m_err = r[8]; m_zero = !r[8] && (r[7:0] == 0);
          m_tag = in_tag;
        end
      end
    end
    m_cyc++;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_in_ready", in_ready, !rst && !m_busy && (!m_valid || out_ready));
      check("m_out_valid", out_valid, m_valid);
      check("m_op_count", op_count, m_cnt);
      if (m_valid) begin
        check("m_out_result", out_result, m_res);
        check("m_out_tag", out_tag, m_tag);
        check("m_out_zero", out_zero, m_zero);
        check("m_out_err", out_err, m_err);
      end
    end
  end

  // Present an op and return 1 time unit after the edge that accepts it.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] tag);
    int n = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=no_accept required=accept at %0t", $time);
    end
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    in_valid = 1'b0; in_op = 3'd0; in_a = 8'h00; in_b = 8'h00; in_tag = 4'h0;
    s1_in_valid = 1'b0; s1_out_ready = 1'b1;
    s1_in_op = 3'd0; s1_in_a = 8'h00; s1_in_b = 8'h00; s1_in_tag = 4'h0;
    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_op_count", op_count, 0);
    check("rst_out_result", out_result, 0);

    // ADD with carry dropped
    send(3'd0, 8'hF0, 8'h20, 4'h1);
    check("add_result", out_result, 8'h10);
    check("add_tag", out_tag, 4'h1);
    check("add_zero", out_zero, 0);
    check("add_err", out_err, 0);
    in_valid = 1'b0;
    step();
    check("add_count", op_count, 1);

    // Back-to-back SUBs: zero then wrap
    send(3'd1, 8'h05, 8'h05, 4'h2);
    check("sub0_result", out_result, 8'h00);
    check("sub0_zero", out_zero, 1);
    send(3'd1, 8'h00, 8'h01, 4'h3);
    check("sub1_result", out_result, 8'hFF);
    check("sub1_zero", out_zero, 0);
    in_valid = 1'b0;
    step();

    // MUL with latency 2
    send(3'd2, 8'h12, 8'h10, 4'h4);
    in_valid = 1'b0;
    check("mul_busy_ready", in_ready, 0);
    step();
    check("mul_wait_valid", out_valid, 0);
    step();
    check("mul_valid", out_valid, 1);
    check("mul_result", out_result, 8'h20);
    check("mul_tag", out_tag, 4'h4);

    // MUL with latency 1 on the second instance
    s1_in_valid = 1'b1; s1_in_op = 3'd2; s1_in_a = 8'h12; s1_in_b = 8'h10; s1_in_tag = 4'h5;
    @(negedge clk);
    check("mul1_in_ready", s1_in_ready, 1);
    step();
    s1_in_valid = 1'b0;
    check("mul1_valid", s1_out_valid, 1);
    check("mul1_result", s1_out_result, 8'h20);
    check("mul1_tag", s1_out_tag, 4'h5);
    check("mul1_no_wait", s1_in_ready, 1);

    // Stream, then stall the output for 3 cycles with an op waiting
    send(3'd0, 8'h01, 8'h02, 4'h6);
    check("s_add_result", out_result, 8'h03);
    send(3'd5, 8'hAA, 8'hFF, 4'h7);
    check("s_xor_result", out_result, 8'h55);
    send(3'd4, 8'h0F, 8'h30, 4'h8);
    check("s_or_result", out_result, 8'h3F);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd0; in_a = 8'h03; in_b = 8'h04; in_tag = 4'h9;
    repeat (3) begin
      step();
      check("stall_result", out_result, 8'h3F);
      check("stall_tag", out_tag, 4'h8);
      check("stall_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    check("post_stall_result", out_result, 8'h07);
    check("post_stall_tag", out_tag, 4'h9);
    in_valid = 1'b0;
    step();

    // Illegal opcode
    send(3'd6, 8'h33, 8'h00, 4'hA);
    check("ill_result", out_result, 8'h00);
    check("ill_err", out_err, 1);
    check("ill_zero", out_zero, 0);
    in_valid = 1'b0;
    step();

    // Reset while a MUL is pending: no product may appear
    send(3'd2, 8'h03, 8'h04, 4'hB);
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("rstmul_valid", out_valid, 0);
    check("rstmul_count", op_count, 0);
    rst = 1'b0;
    repeat (5) begin
      step();
      check("rstmul_no_product", out_valid, 0);
    end

    // Saturate op_count with a continuous stream of ADDs
    in_valid = 1'b1; in_op = 3'd0; in_a = 8'h01; in_b = 8'h01; in_tag = 4'h0;
    repeat (65540) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) step();
    check("sat_count", op_count, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
